aq_mmu_utlb_refill: RTL and testbench

Refill controller on the write side of the uTLB entry array. It accepts a lookup miss and fetches the translation from the jTLB. It picks a victim entry and drives the one-hot entry update strobe plus the shared vpn/ppn/pgs/flg/mmu_on update bus. It sits between the uTLB lookup logic and the jTLB, and discards in-flight refills on SATP write or TLB maintenance.

---
 rtl/aq_mmu_pkg.sv | 27 ++
 rtl/aq_mmu_utlb_refill_if.sv | 32 +++
 rtl/aq_mmu_utlb_refill_victim_sel.sv | 118 +++++++++++
 rtl/aq_mmu_utlb_refill.sv | 165 ++++++++++++++++
 tb/tb_aq_mmu_utlb_refill.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aq_mmu_pkg.sv
// aq_mmu_pkg: shared width constants, page-size encodings and refill FSM states
// for the uTLB refill slice.
package aq_mmu_pkg;

    localparam int unsigned ENTRY_NUM_DEF = 8;
    localparam int unsigned VPN_W         = 27;
    localparam int unsigned PPN_W         = 28;
    localparam int unsigned FLG_W         = 15;
    localparam int unsigned PGS_W         = 3;

    // One-hot page sizes carried on the pgs field
    localparam logic [PGS_W-1:0] PGS_4K = 3'b001;
    localparam logic [PGS_W-1:0] PGS_2M = 3'b010;
    localparam logic [PGS_W-1:0] PGS_1G = 3'b100;

    // Flag bit that tags a machine-mode translation
    localparam int unsigned FLG_MMODE_BIT = 10;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        UPD,
        DISCARD
    } refill_state_e;

endpackage

// File: rtl/aq_mmu_utlb_refill_if.sv
// aq_mmu_utlb_refill_if: uTLB-to-jTLB request/response channel.
// master = refill controller side, slave = jTLB side.
interface aq_mmu_utlb_refill_if
    import aq_mmu_pkg::*;
#(
    parameter int unsigned VPN_WIDTH = VPN_W,
    parameter int unsigned PPN_WIDTH = PPN_W,
    parameter int unsigned FLG_WIDTH = FLG_W,
    parameter int unsigned PGS_WIDTH = PGS_W
);
    logic                 utlb_jtlb_req;
    logic [VPN_WIDTH-1:0] utlb_jtlb_vpn;
    logic                 jtlb_utlb_ack;
    logic                 jtlb_utlb_resp_vld;
    logic                 jtlb_utlb_fault;
    logic [PGS_WIDTH-1:0] jtlb_utlb_pgs;
    logic [PPN_WIDTH-1:0] jtlb_utlb_ppn;
    logic [FLG_WIDTH-1:0] jtlb_utlb_flg;

    modport master (
        output utlb_jtlb_req, utlb_jtlb_vpn,
        input  jtlb_utlb_ack, jtlb_utlb_resp_vld, jtlb_utlb_fault,
               jtlb_utlb_pgs, jtlb_utlb_ppn, jtlb_utlb_flg
    );

    modport slave (
        input  utlb_jtlb_req, utlb_jtlb_vpn,
        output jtlb_utlb_ack, jtlb_utlb_resp_vld, jtlb_utlb_fault,
               jtlb_utlb_pgs, jtlb_utlb_ppn, jtlb_utlb_flg
    );

endinterface

// File: rtl/aq_mmu_utlb_refill_victim_sel.sv
// aq_mmu_utlb_victim_sel: picks the uTLB entry to overwrite.
// Invalid entries are filled first (lowest index). With all entries valid the
// replacement comes from a round-robin pointer, or from a tree pseudo-LRU when
// UTLB_REFILL_PLRU_EN is defined (ENTRY_NUM must then be a power of two).
module aq_mmu_utlb_victim_sel #(
    parameter int unsigned ENTRY_NUM = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [ENTRY_NUM-1:0] i_entry_vld,
    input  logic [ENTRY_NUM-1:0] i_entry_hit,
    input  logic                 i_adv,
    output logic [ENTRY_NUM-1:0] o_victim
);
    localparam int unsigned IDX_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

    logic [ENTRY_NUM-1:0] w_inv_onehot;
    logic                 w_inv_found;
    logic [ENTRY_NUM-1:0] w_repl_onehot;

    // Lowest-index invalid entry has priority over any replacement choice
    always_comb begin
        w_inv_onehot = '0;
        w_inv_found  = 1'b0;
        for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            if (!i_entry_vld[i] && !w_inv_found) begin
                w_inv_onehot[i] = 1'b1;
                w_inv_found     = 1'b1;
            end
        end
    end

    assign o_victim = w_inv_found ? w_inv_onehot : w_repl_onehot;

`ifdef UTLB_REFILL_PLRU_EN
    localparam int unsigned LVLS = $clog2(ENTRY_NUM);

    // Tree nodes in heap order (root = 1); a node bit of 1 points to the right subtree
    logic [ENTRY_NUM-1:1] r_plru;
    logic [ENTRY_NUM-1:1] w_plru_nxt;

    // Mark a leaf as recently used: every ancestor points away from it
    function automatic logic [ENTRY_NUM-1:1] plru_touch(input logic [ENTRY_NUM-1:1] t,
                                                        input logic [IDX_W-1:0]     idx);
        logic [IDX_W:0] node;
        node = {1'b1, idx};
        for (int unsigned l = 0; l < LVLS; l++) begin
            t[node[IDX_W:1]] = ~node[0];
            node = node >> 1;
        end
        return t;
    endfunction

    // Walk from the root following the node bits down to the LRU leaf
    always_comb begin
        logic [IDX_W:0] node;
        node          = (IDX_W+1)'(1);
        w_repl_onehot = '0;
        for (int unsigned l = 0; l < LVLS; l++) begin
            node = {node[IDX_W-1:0], r_plru[node[IDX_W-1:0]]};
        end
        w_repl_onehot[node[IDX_W-1:0]] = 1'b1;
    end

    // Recency update from lookup hits, then from the entry being refilled
    always_comb begin
        logic [IDX_W-1:0] hit_idx;
        logic [IDX_W-1:0] vic_idx;
        logic             hit_found;
        hit_idx    = '0;
        vic_idx    = '0;
        hit_found  = 1'b0;
        for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            if (i_entry_hit[i] && !hit_found) begin
                hit_idx   = IDX_W'(i);
                hit_found = 1'b1;
            end
            if (o_victim[i]) begin
                vic_idx = IDX_W'(i);
            end
        end
        w_plru_nxt = r_plru;
        if (hit_found) begin
            w_plru_nxt = plru_touch(w_plru_nxt, hit_idx);
        end
        if (i_adv) begin
            w_plru_nxt = plru_touch(w_plru_nxt, vic_idx);
        end
    end

    // PLRU tree state
    always_ff @(posedge i_clk) begin
        if (i_rst) r_plru <= '0;
        else       r_plru <= w_plru_nxt;
    end
`else
    logic [IDX_W-1:0] r_ptr;
    logic             w_unused_hit;

    assign w_unused_hit = ^i_entry_hit;

    // Pointer moves only when a full array forces a replacement
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_adv && !w_inv_found) begin
            r_ptr <= (r_ptr == IDX_W'(ENTRY_NUM-1)) ? '0 : r_ptr + IDX_W'(1);
        end
    end

    // Decode the pointer into a one-hot replacement candidate
    always_comb begin
        w_repl_onehot        = '0;
        w_repl_onehot[r_ptr] = 1'b1;
    end
`endif

endmodule

// File: rtl/aq_mmu_utlb_refill.sv
// aq_mmu_utlb_refill: uTLB refill controller. Accepts a lookup miss, fetches
// the translation from the jTLB, and writes it into a victim uTLB entry.
// SATP writes and TLB maintenance discard any refill in flight.
// Optional build macro: UTLB_REFILL_PLRU_EN (pseudo-LRU replacement).
module aq_mmu_utlb_refill
    import aq_mmu_pkg::*;
#(
    parameter int unsigned ENTRY_NUM = ENTRY_NUM_DEF,
    parameter int unsigned VPN_WIDTH = VPN_W,
    parameter int unsigned PPN_WIDTH = PPN_W,
    parameter int unsigned FLG_WIDTH = FLG_W,
    parameter int unsigned PGS_WIDTH = PGS_W
) (
    input  logic                  mmu_top_clk,
    input  logic                  cpurst,
    input  logic                  utlb_miss_vld,
    input  logic [VPN_WIDTH-1:0]  utlb_miss_vpn,
    output logic                  utlb_miss_rdy,
    input  logic [ENTRY_NUM-1:0]  utlb_entry_vld,
    input  logic [ENTRY_NUM-1:0]  utlb_entry_hit,
    aq_mmu_utlb_refill_if.master  jtlb,
    input  logic                  regs_mmu_en,
    input  logic                  cp0_mmu_satp_wen,
    input  logic                  tlboper_xx_clr,
    input  logic                  tlboper_xx_inv_va_req,
    output logic [ENTRY_NUM-1:0]  utlb_entry_upd,
    output logic [VPN_WIDTH-1:0]  utlb_upd_vpn,
    output logic [PPN_WIDTH-1:0]  utlb_upd_ppn,
    output logic [PGS_WIDTH-1:0]  utlb_upd_pgs,
    output logic [FLG_WIDTH-1:0]  utlb_upd_flg,
    output logic                  utlb_upd_mmu_on,
    output logic                  utlb_refill_done,
    output logic                  utlb_refill_fault
);
    refill_state_e        r_state, w_state_nxt;
    logic                 w_abort;
    logic                 w_accept;
    logic                 w_latch_resp;
    logic                 w_fault_set;
    logic                 w_adv;
    logic [ENTRY_NUM-1:0] w_victim;
    logic                 r_abort_seen;
    logic [VPN_WIDTH-1:0] r_vpn;
    logic                 r_mmu_on;
    logic [VPN_WIDTH-1:0] r_upd_vpn;
    logic [PPN_WIDTH-1:0] r_upd_ppn;
    logic [PGS_WIDTH-1:0] r_upd_pgs;
    logic [FLG_WIDTH-1:0] r_upd_flg;
    logic                 r_upd_mmu_on;
    logic                 r_fault;

    assign w_abort            = cp0_mmu_satp_wen | tlboper_xx_clr | tlboper_xx_inv_va_req;
    assign jtlb.utlb_jtlb_vpn = r_vpn;
    assign utlb_upd_vpn       = r_upd_vpn;
    assign utlb_upd_ppn       = r_upd_ppn;
    assign utlb_upd_pgs       = r_upd_pgs;
    assign utlb_upd_flg       = r_upd_flg;
    assign utlb_upd_mmu_on    = r_upd_mmu_on;
    assign utlb_refill_fault  = r_fault;

    aq_mmu_utlb_victim_sel #(
        .ENTRY_NUM (ENTRY_NUM)
    ) u_victim_sel (
        .i_clk       (mmu_top_clk),
        .i_rst       (cpurst),
        .i_entry_vld (utlb_entry_vld),
        .i_entry_hit (utlb_entry_hit),
        .i_adv       (w_adv),
        .o_victim    (w_victim)
    );

    // Refill state register
    always_ff @(posedge mmu_top_clk) begin
        if (cpurst) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake/update strobes
    always_comb begin
        w_state_nxt        = r_state;
        utlb_miss_rdy      = 1'b0;
        jtlb.utlb_jtlb_req = 1'b0;
        w_accept           = 1'b0;
        w_latch_resp       = 1'b0;
        w_fault_set        = 1'b0;
        w_adv              = 1'b0;
        utlb_entry_upd     = '0;
        utlb_refill_done   = 1'b0;
        unique case (r_state)
            IDLE: begin
                utlb_miss_rdy = 1'b1;
                if (utlb_miss_vld && !w_abort) begin
                    w_accept    = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                // The request stays up until acked; an abort only dooms the response
                jtlb.utlb_jtlb_req = 1'b1;
                if (jtlb.jtlb_utlb_ack) begin
                    w_state_nxt = (w_abort || r_abort_seen) ? DISCARD : WAIT;
                end
            end
            WAIT: begin
                if (jtlb.jtlb_utlb_resp_vld) begin
                    w_state_nxt = IDLE;
                    if (!w_abort) begin
                        if (jtlb.jtlb_utlb_fault) begin
                            w_fault_set = 1'b1;
                        end else begin
                            w_latch_resp = 1'b1;
                            w_state_nxt  = UPD;
                        end
                    end
                end else if (w_abort) begin
                    w_state_nxt = DISCARD;
                end
            end
            UPD: begin
                w_state_nxt = IDLE;
                if (!w_abort) begin
                    utlb_entry_upd   = w_victim;
                    utlb_refill_done = 1'b1;
                    w_adv            = 1'b1;
                end
            end
            DISCARD: begin
                if (jtlb.jtlb_utlb_resp_vld) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Miss capture, sticky abort, response payload and fault pulse
    always_ff @(posedge mmu_top_clk) begin
        if (cpurst) begin
            r_abort_seen <= 1'b0;
            r_vpn        <= '0;
            r_mmu_on     <= 1'b0;
            r_upd_vpn    <= '0;
            r_upd_ppn    <= '0;
            r_upd_pgs    <= '0;
            r_upd_flg    <= '0;
            r_upd_mmu_on <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_abort_seen <= (r_state == REQ) && !jtlb.jtlb_utlb_ack && (w_abort || r_abort_seen);
            r_fault      <= w_fault_set;
            if (w_accept) begin
                r_vpn    <= utlb_miss_vpn;
                r_mmu_on <= regs_mmu_en;
            end
            if (w_latch_resp) begin
                r_upd_vpn    <= r_vpn;
                r_upd_ppn    <= jtlb.jtlb_utlb_ppn;
                r_upd_pgs    <= jtlb.jtlb_utlb_pgs;
                r_upd_flg    <= jtlb.jtlb_utlb_flg;
                r_upd_mmu_on <= r_mmu_on;
            end
        end
    end

endmodule

// File: tb/tb_aq_mmu_utlb_refill.sv
// tb_aq_mmu_utlb_refill: directed bench for the uTLB refill controller with a
// transaction-level reference model compared every cycle, plus literal checks.
`timescale 1ns/1ps
module tb_aq_mmu_utlb_refill;
    import aq_mmu_pkg::*;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_vld;
    logic [26:0]  miss_vpn;
    logic         miss_rdy;
    logic [N-1:0] entry_vld;
    logic [N-1:0] entry_hit;
    logic         regs_mmu_en;
    logic         satp_wen;
    logic         tlb_clr;
    logic         inv_va;
    logic [N-1:0] upd;
    logic [26:0]  upd_vpn;
    logic [27:0]  upd_ppn;
    logic [2:0]   upd_pgs;
    logic [14:0]  upd_flg;
    logic         upd_on;
    logic         done;
    logic         refill_fault;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aq_mmu_utlb_refill_if #(.VPN_WIDTH(27), .PPN_WIDTH(28), .FLG_WIDTH(15), .PGS_WIDTH(3)) jif ();

    aq_mmu_utlb_refill #(
        .ENTRY_NUM (N), .VPN_WIDTH (27), .PPN_WIDTH (28), .FLG_WIDTH (15), .PGS_WIDTH (3)
    ) dut (
        .mmu_top_clk           (clk),
        .cpurst                (rst),
        .utlb_miss_vld         (miss_vld),
        .utlb_miss_vpn         (miss_vpn),
        .utlb_miss_rdy         (miss_rdy),
        .utlb_entry_vld        (entry_vld),
        .utlb_entry_hit        (entry_hit),
        .jtlb                  (jif),
        .regs_mmu_en           (regs_mmu_en),
        .cp0_mmu_satp_wen      (satp_wen),
        .tlboper_xx_clr        (tlb_clr),
        .tlboper_xx_inv_va_req (inv_va),
        .utlb_entry_upd        (upd),
        .utlb_upd_vpn          (upd_vpn),
        .utlb_upd_ppn          (upd_ppn),
        .utlb_upd_pgs          (upd_pgs),
        .utlb_upd_flg          (upd_flg),
        .utlb_upd_mmu_on       (upd_on),
        .utlb_refill_done      (done),
        .utlb_refill_fault     (refill_fault)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference victim: first invalid entry, else the round-robin slot
    function automatic logic [N-1:0] model_victim(input logic [N-1:0] vld, input int unsigned rr);
        logic [N-1:0] one;
        one = 1;
        for (int i = 0; i < N; i++) begin
            if (!vld[i]) return one << i;
        end
        return one << rr;
    endfunction

    // Transaction-level model: one outstanding refill, tracked as flags
    bit           m_init     = 0;
    bit           m_busy     = 0;
    bit           m_acked    = 0;
    bit           m_doomed   = 0;
    bit           m_upd_due  = 0;
    bit           m_fault_due = 0;
    int unsigned  m_rr       = 0;
    logic [26:0]  m_vpn      = '0;
    logic         m_on       = 1'b0;
    logic [26:0]  m_d_vpn    = '0;
    logic [27:0]  m_d_ppn    = '0;
    logic [2:0]   m_d_pgs    = '0;
    logic [14:0]  m_d_flg    = '0;
    logic         m_d_on     = 1'b0;

    always @(negedge clk) begin
        logic         abt;
        logic [N-1:0] e_upd;
        logic         e_done;
        abt    = satp_wen | tlb_clr | inv_va;
        e_upd  = '0;
        e_done = 1'b0;
        if (m_upd_due && !abt) begin
            e_upd  = model_victim(entry_vld, m_rr);
            e_done = 1'b1;
        end
        if (m_init) begin
            check("m_miss_rdy", miss_rdy, !m_busy && !m_upd_due);
            check("m_jtlb_req", jif.utlb_jtlb_req, m_busy && !m_acked);
            check("m_upd", upd, e_upd);
            check("m_done", done, e_done);
            check("m_fault", refill_fault, m_fault_due);
            if (m_busy && !m_acked) check("m_jtlb_vpn", jif.utlb_jtlb_vpn, m_vpn);
            if (e_done) begin
                check("m_upd_vpn", upd_vpn, m_d_vpn);
                check("m_upd_ppn", upd_ppn, m_d_ppn);
                check("m_upd_pgs", upd_pgs, m_d_pgs);
                check("m_upd_flg", upd_flg, m_d_flg);
                check("m_upd_on", upd_on, m_d_on);
            end
        end
        if (rst) begin
            m_init = 1; m_busy = 0; m_acked = 0; m_doomed = 0;
            m_upd_due = 0; m_fault_due = 0; m_rr = 0;
        end else begin
            m_fault_due = 0;
            if (m_upd_due) begin
                m_upd_due = 0;
                if (e_done && (&entry_vld)) m_rr = (m_rr + 1) % N;
            end else if (!m_busy) begin
                if (miss_vld && !abt) begin
                    m_busy = 1; m_acked = 0; m_doomed = 0;
                    m_vpn = miss_vpn; m_on = regs_mmu_en;
                end
            end else if (!m_acked) begin
                if (abt) m_doomed = 1;
                if (jif.jtlb_utlb_ack) m_acked = 1;
            end else begin
                if (jif.jtlb_utlb_resp_vld) begin
                    m_busy = 0;
                    if (!m_doomed && !abt) begin
                        if (jif.jtlb_utlb_fault) begin
                            m_fault_due = 1;
                        end else begin
                            m_upd_due = 1;
                            m_d_vpn = m_vpn;
                            m_d_ppn = jif.jtlb_utlb_ppn;
                            m_d_pgs = jif.jtlb_utlb_pgs;
                            m_d_flg = jif.jtlb_utlb_flg;
                            m_d_on  = m_on;
                        end
                    end
                end else if (abt) begin
                    m_doomed = 1;
                end
            end
        end
    end

    // One refill: miss, ack after ack_dly, response after resp_dly, sample the final cycle
    task automatic refill(input logic [26:0] vpn, input int ack_dly, input int resp_dly,
                          input logic flt, input logic [27:0] ppn, input logic [2:0] pgs,
                          input logic [14:0] flg, input logic upd_abort,
                          output int lat, output logic [N-1:0] s_upd,
                          output logic s_done, output logic s_fault);
        int n;
        int acc;
        miss_vld = 1'b1;
        miss_vpn = vpn;
        n = 0;
        @(negedge clk);
        while (!miss_rdy && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (!miss_rdy) check("accept_timeout", miss_rdy, 1);
        acc = cyc;
        tick();
        miss_vld = 1'b0;
        miss_vpn = '0;
        repeat (ack_dly) tick();
        jif.jtlb_utlb_ack = 1'b1;
        tick();
        jif.jtlb_utlb_ack = 1'b0;
        repeat (resp_dly) tick();
        jif.jtlb_utlb_resp_vld = 1'b1;
        jif.jtlb_utlb_fault    = flt;
        jif.jtlb_utlb_ppn      = ppn;
        jif.jtlb_utlb_pgs      = pgs;
        jif.jtlb_utlb_flg      = flg;
        tick();
        jif.jtlb_utlb_resp_vld = 1'b0;
        jif.jtlb_utlb_fault    = 1'b0;
        if (upd_abort) satp_wen = 1'b1;
        @(negedge clk);
        lat     = cyc - acc;
        s_upd   = upd;
        s_done  = done;
        s_fault = refill_fault;
        tick();
        satp_wen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           lat;
        logic [N-1:0] s_upd;
        logic         s_done;
        logic         s_flt;
        logic [N-1:0] one;
        one = 1;

        rst = 1'b1; miss_vld = 1'b0; miss_vpn = '0; entry_vld = '0; entry_hit = '0;
        regs_mmu_en = 1'b0; satp_wen = 1'b0; tlb_clr = 1'b0; inv_va = 1'b0;
        jif.jtlb_utlb_ack = 1'b0; jif.jtlb_utlb_resp_vld = 1'b0; jif.jtlb_utlb_fault = 1'b0;
        jif.jtlb_utlb_pgs = '0; jif.jtlb_utlb_ppn = '0; jif.jtlb_utlb_flg = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_miss_rdy", miss_rdy, 1);
        check("rst_jtlb_req", jif.utlb_jtlb_req, 0);
        check("rst_upd", upd, 0);
        check("rst_done", done, 0);
        check("rst_fault", refill_fault, 0);
        check("rst_upd_ppn", upd_ppn, 0);
        tick();

        // Minimum-latency refill into an empty array
        regs_mmu_en = 1'b1;
        refill(27'h12345, 0, 0, 1'b0, 28'hABCDE, PGS_4K, 15'(1) << FLG_MMODE_BIT, 1'b0,
               lat, s_upd, s_done, s_flt);
        check("t1_latency_cycles", lat + 1, 4);
        check("t1_upd", s_upd, 8'h01);
        check("t1_done", s_done, 1);
        check("t1_upd_ppn", upd_ppn, 28'hABCDE);
        check("t1_upd_vpn", upd_vpn, 27'h12345);
        check("t1_upd_pgs", upd_pgs, 3'b001);
        check("t1_upd_flg", upd_flg, 15'h0400);
        check("t1_upd_mmu_on", upd_on, 1);

        // Full array: round-robin through all entries, then wrap
        entry_vld = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            refill(27'h100 + 27'(k), k % 3, k % 2, 1'b0, 28'h2000 + 28'(k), PGS_2M, 15'(k), 1'b0,
                   lat, s_upd, s_done, s_flt);
            check("t2_rr_upd", s_upd, one << k);
        end
        refill(27'h200, 0, 0, 1'b0, 28'h3000, PGS_1G, 15'h7, 1'b0, lat, s_upd, s_done, s_flt);
        check("t2_wrap_upd", s_upd, 8'h01);

        // Invalid entry takes priority and leaves the pointer alone
        entry_vld = 8'hFB;
        regs_mmu_en = 1'b0;
        refill(27'h300, 1, 1, 1'b0, 28'h4000, PGS_4K, 15'h1, 1'b0, lat, s_upd, s_done, s_flt);
        check("t3_invalid_upd", s_upd, 8'h04);
        entry_vld = 8'hFF;
        refill(27'h301, 0, 0, 1'b0, 28'h4001, PGS_4K, 15'h2, 1'b0, lat, s_upd, s_done, s_flt);
        check("t3_ptr_kept_upd", s_upd, 8'h02);

        // Fault response: pulse, no write
        refill(27'h400, 0, 1, 1'b1, 28'h5000, PGS_4K, 15'h0, 1'b0, lat, s_upd, s_done, s_flt);
        check("t4_fault", s_flt, 1);
        check("t4_fault_upd", s_upd, 0);
        check("t4_fault_done", s_done, 0);

        // SATP write during the update cycle suppresses the write
        refill(27'h500, 0, 0, 1'b0, 28'h6000, PGS_4K, 15'h3, 1'b1, lat, s_upd, s_done, s_flt);
        check("t5_satp_upd", s_upd, 0);
        check("t5_satp_done", s_done, 0);
        refill(27'h501, 0, 0, 1'b0, 28'h6001, PGS_4K, 15'h3, 1'b0, lat, s_upd, s_done, s_flt);
        check("t5_next_upd", s_upd, 8'h04);

        // TLB clear in WAIT: response later dropped
        miss_vld = 1'b1; miss_vpn = 27'h7777;
        @(negedge clk);
        check("t6_accept_rdy", miss_rdy, 1);
        tick(); miss_vld = 1'b0;
        jif.jtlb_utlb_ack = 1'b1;
        tick(); jif.jtlb_utlb_ack = 1'b0;
        tlb_clr = 1'b1;
        tick(); tlb_clr = 1'b0;
        @(negedge clk);
        check("t6_discard_rdy", miss_rdy, 0);
        tick();
        jif.jtlb_utlb_resp_vld = 1'b1; jif.jtlb_utlb_ppn = 28'hDEAD;
        @(negedge clk);
        check("t6_resp_done", done, 0);
        tick(); jif.jtlb_utlb_resp_vld = 1'b0;
        @(negedge clk);
        check("t6_after_rdy", miss_rdy, 1);
        check("t6_after_upd", upd, 0);
        check("t6_after_done", done, 0);
        tick();

        // Abort in REQ without ack: request held, then discard until response
        miss_vld = 1'b1; miss_vpn = 27'h5555;
        tick(); miss_vld = 1'b0;
        inv_va = 1'b1;
        @(negedge clk);
        check("t7_req_abort", jif.utlb_jtlb_req, 1);
        tick(); inv_va = 1'b0;
        @(negedge clk);
        check("t7_req_held", jif.utlb_jtlb_req, 1);
        check("t7_req_vpn", jif.utlb_jtlb_vpn, 27'h5555);
        tick(); jif.jtlb_utlb_ack = 1'b1;
        tick(); jif.jtlb_utlb_ack = 1'b0;
        @(negedge clk);
        check("t7_discard_req", jif.utlb_jtlb_req, 0);
        check("t7_discard_rdy", miss_rdy, 0);
        tick(); jif.jtlb_utlb_resp_vld = 1'b1;
        tick(); jif.jtlb_utlb_resp_vld = 1'b0;
        @(negedge clk);
        check("t7_idle_rdy", miss_rdy, 1);
        check("t7_idle_done", done, 0);
        tick();

        // Miss raised together with an abort is ignored
        miss_vld = 1'b1; miss_vpn = 27'h6666; satp_wen = 1'b1;
        @(negedge clk);
        check("t8_rdy", miss_rdy, 1);
        tick(); miss_vld = 1'b0; satp_wen = 1'b0;
        @(negedge clk);
        check("t8_no_req", jif.utlb_jtlb_req, 0);
        check("t8_still_rdy", miss_rdy, 1);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
